// File: rtl/atom_loader_pkg.sv
// Shared types and .ATM header layout for the Atom image loader.
package atom_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_SKIP,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam int ATM_HDR_LEN = 22;

  // Byte offsets inside the header; bytes 0-15 hold the file name.
  localparam logic [4:0] HDR_LOAD_LO = 5'd16;
  localparam logic [4:0] HDR_LOAD_HI = 5'd17;
  localparam logic [4:0] HDR_EXEC_LO = 5'd18;
  localparam logic [4:0] HDR_EXEC_HI = 5'd19;
  localparam logic [4:0] HDR_LEN_LO  = 5'd20;
  localparam logic [4:0] HDR_LEN_HI  = 5'd21;

  function automatic logic [15:0] le16(input logic [7:0] lo, input logic [7:0] hi);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/atom_loader_fifo.sv
// Show-ahead byte FIFO; push when full and pop when empty are ignored, clr empties it.
// Zero-latency read: pop_dat is the head entry whenever empty is low.
module atom_loader_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic                     clk_sys,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             push_dat,
  input  logic                     pop,
  output logic [W-1:0]             pop_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (do_push && !clr) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/atom_loader.sv
// Streams an HPS download into Atom memory, one write per two cycles; ioctl_wait throttles at FIFO_DEPTH-1.
// ATOM_LOADER_ATM_HEADER_EN enables .ATM header parsing; otherwise raw images load at LOAD_BASE.
module atom_loader
  import atom_loader_pkg::*;
#(
  parameter logic [15:0] LOAD_BASE  = 16'h2900,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        cpu_hold,
  output logic        mem_we_n,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic [15:0] exec_addr,
  output logic        load_done,
  output logic        err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] WAIT_LVL = CW'(FIFO_DEPTH - 1);

  state_t        state;
  logic          dl_q;
  logic          dl_rise;
  logic          dl_fall;
  logic          phase;
  logic          drain_wr;
  logic          drain_write;
  logic          pop;
  logic          push_en;
  logic          wr_byte;
  logic [7:0]    pop_dat;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_nxt;
  logic          unused_addr;

`ifdef ATOM_LOADER_ATM_HEADER_EN
  logic [4:0]    hdr_cnt;
  logic [15:0]   rem;
  logic [15:0]   load_reg;
  logic [15:0]   exec_reg;
  logic [7:0]    len_lo;
  logic [15:0]   hdr_len;

  assign hdr_len     = le16(len_lo, pop_dat);
  assign drain_write = drain_wr && (rem != 16'h0);
`else
  assign drain_write = drain_wr;
`endif

  assign unused_addr = ^ioctl_addr;
  assign dl_rise     = ioctl_download && !dl_q;
  assign dl_fall     = !ioctl_download && dl_q;
  assign push_en     = ioctl_wr && !fifo_full && !dl_rise;
  assign wr_byte     = pop && !phase &&
                       ((state == S_DATA) || ((state == S_DRAIN) && drain_write));

  always_comb begin
    pop = 1'b0;
    case (state)
      S_HDR:   pop = !fifo_empty;
      S_DATA:  pop = !fifo_empty && !phase;
      S_SKIP:  pop = !fifo_empty;
      S_DRAIN: pop = !fifo_empty && (!drain_write || !phase);
      default: pop = 1'b0;
    endcase
  end

  // ioctl_wait is registered from the next-cycle level so it tracks the FIFO count exactly.
  always_comb begin
    count_nxt = fifo_count;
    if (dl_rise)              count_nxt = '0;
    else if (push_en && !pop) count_nxt = fifo_count + 1'b1;
    else if (!push_en && pop) count_nxt = fifo_count - 1'b1;
  end

  atom_loader_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (8)
  ) u_fifo (
    .clk_sys  (clk_sys),
    .reset    (reset),
    .clr      (dl_rise),
    .push     (push_en),
    .push_dat (ioctl_dout),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      dl_q       <= 1'b0;
      phase      <= 1'b0;
      drain_wr   <= 1'b0;
      mem_we_n   <= 1'b1;
      mem_addr   <= 16'h0;
      mem_din    <= 8'h0;
      ioctl_wait <= 1'b0;
      cpu_hold   <= 1'b0;
      exec_addr  <= 16'h0;
      load_done  <= 1'b0;
      err        <= 1'b0;
`ifdef ATOM_LOADER_ATM_HEADER_EN
      hdr_cnt    <= 5'd0;
      rem        <= 16'h0;
      load_reg   <= 16'h0;
      exec_reg   <= 16'h0;
      len_lo     <= 8'h0;
`endif
    end else begin
      dl_q       <= ioctl_download;
      ioctl_wait <= (count_nxt >= WAIT_LVL);
      load_done  <= 1'b0;
      if (ioctl_wr && fifo_full) err <= 1'b1;

      if (dl_rise) begin
        err      <= 1'b0;
        phase    <= 1'b0;
        drain_wr <= 1'b0;
        mem_we_n <= 1'b1;
        cpu_hold <= 1'b1;
`ifdef ATOM_LOADER_ATM_HEADER_EN
        hdr_cnt  <= 5'd0;
        load_reg <= LOAD_BASE;
        exec_reg <= LOAD_BASE;
        state    <= S_HDR;
`else
        mem_addr <= LOAD_BASE;
        state    <= S_DATA;
`endif
      end else begin
        // Write engine shared by DATA and DRAIN; a pending phase B always completes.
        if (phase) begin
          mem_we_n <= 1'b1;
          mem_addr <= mem_addr + 1'b1;
          phase    <= 1'b0;
        end else if (wr_byte) begin
          mem_din  <= pop_dat;
          mem_we_n <= 1'b0;
          phase    <= 1'b1;
`ifdef ATOM_LOADER_ATM_HEADER_EN
          rem      <= rem - 1'b1;
`endif
        end

        case (state)
          S_IDLE: ;
`ifdef ATOM_LOADER_ATM_HEADER_EN
          S_HDR: begin
            if (dl_fall) begin
              err      <= 1'b1;
              drain_wr <= 1'b0;
              state    <= S_DRAIN;
            end else if (pop) begin
              hdr_cnt <= hdr_cnt + 1'b1;
              case (hdr_cnt)
                HDR_LOAD_LO: load_reg[7:0]  <= pop_dat;
                HDR_LOAD_HI: load_reg[15:8] <= pop_dat;
                HDR_EXEC_LO: exec_reg[7:0]  <= pop_dat;
                HDR_EXEC_HI: exec_reg[15:8] <= pop_dat;
                HDR_LEN_LO:  len_lo         <= pop_dat;
                default: ;
              endcase
              if (hdr_cnt == HDR_LEN_HI) begin
                rem      <= hdr_len;
                mem_addr <= load_reg;
                state    <= (hdr_len == 16'h0) ? S_SKIP : S_DATA;
              end
            end
          end
`endif
          S_DATA: begin
            if (dl_fall) begin
              drain_wr <= 1'b1;
              state    <= S_DRAIN;
            end
`ifdef ATOM_LOADER_ATM_HEADER_EN
            else if (phase && (rem == 16'h0)) begin
              state <= S_SKIP;
            end
`endif
          end
          S_SKIP: begin
            if (dl_fall) begin
              drain_wr <= 1'b0;
              state    <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (fifo_empty && !phase) begin
`ifdef ATOM_LOADER_ATM_HEADER_EN
              if (drain_wr && (rem != 16'h0)) err <= 1'b1;
`endif
              state <= S_DONE;
            end
          end
          S_DONE: begin
`ifdef ATOM_LOADER_ATM_HEADER_EN
            exec_addr <= exec_reg;
`else
            exec_addr <= LOAD_BASE;
`endif
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
            state     <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
